// File: rtl/core_rf_wport_arb.sv
// Round-robin arbiter/sequencer for the single register-file write port.
// Holds wen until done, discards x0 writes, and aborts a stuck write after TIMEOUT cycles.
module core_rf_wport_arb #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*5-1:0]  req_addr,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               reg_wen,
    output logic [4:0]         reg_addr,
    output logic [31:0]        reg_din,
    input  logic               reg_done,
    output logic               busy,
    output logic               err_timeout,
    input  logic               err_clr
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     last_q, last_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [4:0]        addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic [NREQ-1:0]   ready_q, ready_d;
    logic              err_q, err_d;

    logic [GW-1:0]     grant;
    logic              grant_vld;
    logic [4:0]        sel_addr;
    logic [31:0]       sel_data;
    int unsigned       idx;

    // Search starts one past the last grant and wraps, so index 0 wins first after reset.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        idx       = 0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = (32'(last_q) + off) % NREQ;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!grant_vld && (i == idx) && req_valid[i]) begin
                    grant_vld = 1'b1;
                    grant     = GW'(i);
                    sel_addr  = req_addr[5*i +: 5];
                    sel_data  = req_data[32*i +: 32];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        din_d   = din_q;
        ready_d = '0;
        err_d   = err_clr ? 1'b0 : err_q;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    last_d = grant;
                    addr_d = sel_addr;
                    din_d  = sel_data;
                    if (sel_addr != 5'd0) begin
                        state_d = StIssue;
                        wen_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = StDone;
                        ready_d = NREQ'(1) << grant;
                    end
                end
            end
            StIssue: begin
                if (reg_done) begin
                    state_d = StDone;
                    wen_d   = 1'b0;
                    ready_d = NREQ'(1) << last_q;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = StDone;
                    wen_d   = 1'b0;
                    ready_d = NREQ'(1) << last_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= GW'(NREQ - 1);
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            ready_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign req_ready   = ready_q;
    assign reg_wen     = wen_q;
    assign reg_addr    = addr_q;
    assign reg_din     = din_q;
    assign busy        = (state_q != StIdle);
    assign err_timeout = err_q;

endmodule
